bno_spi_bus_arbiter: RTL
========================

// Module: bno_spi_bus_arbiter
// PURPOSE
// - Shares one spi_master (shared sclk/mosi) between N_REQ bno085_controller_new instances, e.g. left and right hand.
// - Round-robin, transaction-level arbitration; the owner holds the bus for a whole CS-framed transfer.
// - Muxes master-bound controls and routes returned data to the owner; gates per-sensor cs_n and selects miso.
// - Sits between the controllers and spi_master in drum_trigger_top.
// PARAMETERS
// N_REQ         2      number of requesting controllers (2..4)
// GAP_CYCLES    4      idle clk cycles after a release before any new grant (CS deassert time)
// HOLD_TIMEOUT  65535  max clk cycles one grant may last; 0 disables the watchdog
// PORTS
// clk            in   1        system clock (3 MHz HSOSC)
// rst            in   1        asynchronous reset, active-high
// req            in   N_REQ    per-controller bus request; held high for the whole transaction
// gnt            out  N_REQ    one-hot grant
// req_start      in   N_REQ    per-controller spi start
// req_tx_valid   in   N_REQ    per-controller tx_valid
// req_tx_data    in   8*N_REQ  per-controller tx byte, packed, [8i+7:8i]
// req_cs_n       in   N_REQ    per-controller chip select
// req_tx_ready   out  N_REQ    tx_ready, owner only
// req_rx_valid   out  N_REQ    rx_valid pulse, owner only
// req_rx_data    out  8        rx byte, broadcast (qualify with req_rx_valid)
// req_busy       out  N_REQ    busy: master busy to owner; constant 1 to non-owners
// spi_start      out  1        to spi_master
// spi_tx_valid   out  1        to spi_master
// spi_tx_data    out  8        to spi_master
// spi_tx_ready   in   1        from spi_master
// spi_rx_valid   in   1        from spi_master
// spi_rx_data    in   8        from spi_master
// spi_busy       in   1        from spi_master
// cs_n           out  N_REQ    sensor chip selects
// timeout_err    out  1        sticky watchdog flag
// BEHAVIOUR
// - Reset values: gnt=0, cs_n=all 1, spi_start/spi_tx_valid=0, spi_tx_data=0, req_busy=all 1, req_tx_ready=0, req_rx_valid=0, timeout_err=0, RR pointer=0, state IDLE.
// - FSM states:
//   - IDLE->GRANT when any req=1. Winner is the first set req at or after the pointer. gnt is registered and asserts 1 cycle after req is seen.
//   - GRANT->DRAIN when req[owner] falls, or on watchdog expiry.
//   - DRAIN->GAP when spi_busy=0.
//   - GAP->IDLE after GAP_CYCLES cycles. The pointer advances to owner+1 mod N_REQ on leaving GRANT.
// - Master-bound mux: in GRANT only, the owner's start/tx_valid/tx_data pass combinationally. Otherwise spi_start=spi_tx_valid=0.
// - Return path: req_tx_ready[i]=spi_tx_ready&&gnt[i]; req_rx_valid[i]=spi_rx_valid&&gnt[i]; req_busy[i]=gnt[i]?spi_busy:1.
// - A byte completing in DRAIN is not delivered (gnt already 0).
// - cs_n[i]=req_cs_n[i] | ~gnt[i]. A non-owner can never assert its sensor CS.
// - MISO select is not in this block. Top-level muxes miso with gnt.
// - Watchdog: counts cycles in GRANT, cleared on every new grant. At count==HOLD_TIMEOUT-1:
//   - force release and set timeout_err (sticky until rst);
//   - the offending requester is skipped by the pointer;
//   - it may re-request only after dropping req for at least 1 cycle.
// - Simultaneous release and new request: the releasing owner is lowest priority next round. A single requester is re-granted after the gap.
// - req dropping while spi_busy=1: gnt drops immediately and the master finishes unobserved in DRAIN.
// - Reset mid-transfer: all cs_n high asynchronously; spi_master is reset separately.
// - Counter widths: gap = $clog2(GAP_CYCLES+1), watchdog = $clog2(HOLD_TIMEOUT+1). No wrap: both saturate at their terminal value.
// STRUCTURE
// - Package bno_spi_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_GRANT, ARB_DRAIN, ARB_GAP}, N_REQ_MAX=4, DEFAULT_GAP_CYCLES.
// - One sub-module: rr_pick (combinational round-robin priority picker: req, pointer -> one-hot winner). Everything else is flat.
// TESTING
// 1. Reset then req=2'b01 -> gnt=2'b01 on the second clk; 3-byte transfer; rx bytes A5,5A,FF seen only on req_rx_valid[0].
// 2. req=2'b11 held continuously -> grants alternate 01,10,01. Each gap is exactly GAP_CYCLES cycles with cs_n=2'b11.
// 3. Non-owner drives req_cs_n=0 and req_start=1 -> cs_n stays 1 for it; spi_start sourced only from the owner.
// 4. HOLD_TIMEOUT=100, owner never drops req -> gnt falls at cycle 100, timeout_err=1, the other requester is granted next.
// 5. Owner drops req while spi_busy=1 -> gnt=0 same cycle; no grant issued until spi_busy=0 plus GAP_CYCLES.
// 6. Assert rst during GRANT mid-byte -> cs_n=all 1 and gnt=0 asynchronously; normal arbitration after release.

Source files
------------

// File: rtl/bno_spi_arb_pkg.sv
// Shared types and constants for the BNO085 SPI bus arbiter.
// Holds the arbiter state encoding and a one-hot to index helper.
package bno_spi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN,
    ARB_GAP
  } arb_state_t;

  localparam int N_REQ_MAX          = 4;
  localparam int DEFAULT_GAP_CYCLES = 4;

  function automatic int onehot_idx(input logic [N_REQ_MAX-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N_REQ_MAX; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/bno_spi_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request
// at or after the pointer, wrapping around, as a one-hot vector.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win
);

  int   idx;
  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx] && !found) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bno_spi_bus_arbiter.sv
// Transaction-level round-robin arbiter sharing one spi_master between
// several BNO085 controllers; gates sensor chip selects by grant.
module bno_spi_bus_arbiter
  import bno_spi_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
  parameter int HOLD_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gnt,
  input  logic [N_REQ-1:0]   req_start,
  input  logic [N_REQ-1:0]   req_tx_valid,
  input  logic [8*N_REQ-1:0] req_tx_data,
  input  logic [N_REQ-1:0]   req_cs_n,
  output logic [N_REQ-1:0]   req_tx_ready,
  output logic [N_REQ-1:0]   req_rx_valid,
  output logic [7:0]         req_rx_data,
  output logic [N_REQ-1:0]   req_busy,
  output logic               spi_start,
  output logic               spi_tx_valid,
  output logic [7:0]         spi_tx_data,
  input  logic               spi_tx_ready,
  input  logic               spi_rx_valid,
  input  logic [7:0]         spi_rx_data,
  input  logic               spi_busy,
  output logic [N_REQ-1:0]   cs_n,
  output logic               timeout_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int WD_W  = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0]  WD_LAST  = (HOLD_TIMEOUT > 0) ? WD_W'(HOLD_TIMEOUT - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  arb_state_t           state, state_nx;
  logic [N_REQ-1:0]     gnt_r;
  logic [N_REQ-1:0]     blocked;
  logic [N_REQ-1:0]     req_eff;
  logic [N_REQ-1:0]     win;
  logic [N_REQ_MAX-1:0] win_ext;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     owner;
  logic [GAP_W-1:0]     gap_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic                 owner_req;
  logic                 wd_expire;
  logic                 gap_done;

  // A requester that timed out stays masked until it lets go of req.
  assign req_eff   = req & ~blocked;
  assign win_ext   = N_REQ_MAX'(win);
  assign owner_req = |(req & gnt_r);
  assign wd_expire = (HOLD_TIMEOUT > 0) && (wd_cnt == WD_LAST);
  assign gap_done  = (gap_cnt == GAP_LAST);

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_eff),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE:  if (|req_eff)                 state_nx = ARB_GRANT;
      ARB_GRANT: if (!owner_req || wd_expire)  state_nx = ARB_DRAIN;
      ARB_DRAIN: if (!spi_busy)                state_nx = ARB_GAP;
      ARB_GAP:   if (gap_done)                 state_nx = ARB_IDLE;
      default:                                 state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      gnt_r       <= '0;
      blocked     <= '0;
      ptr         <= '0;
      owner       <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ARB_GRANT && wd_expire)
        blocked <= (blocked & req) | gnt_r;
      else
        blocked <= blocked & req;
      unique case (state)
        ARB_IDLE: begin
          if (state_nx == ARB_GRANT) begin
            gnt_r  <= win;
            owner  <= PTR_W'(onehot_idx(win_ext));
            wd_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          if (state_nx == ARB_DRAIN) begin
            gnt_r <= '0;
            ptr   <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
            if (wd_expire) timeout_err <= 1'b1;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ARB_DRAIN: gap_cnt <= '0;
        ARB_GAP:   if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
        default:   gnt_r <= '0;
      endcase
    end
  end

  // Grant drops combinationally as soon as the owner releases req.
  assign gnt          = gnt_r & req;
  assign spi_start    = |(req_start & gnt);
  assign spi_tx_valid = |(req_tx_valid & gnt);
  assign req_tx_ready = {N_REQ{spi_tx_ready}} & gnt;
  assign req_rx_valid = {N_REQ{spi_rx_valid}} & gnt;
  assign req_rx_data  = spi_rx_data;
  assign req_busy     = ~gnt | {N_REQ{spi_busy}};
  assign cs_n         = req_cs_n | ~gnt;

  always_comb begin
    spi_tx_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) spi_tx_data = spi_tx_data | req_tx_data[8*i +: 8];
    end
  end

endmodule
